// File: rtl/sram_fifo_ctrl_240x32.sv
// FIFO controller around a 1w1r SRAM macro (DEPTH x DATA_WIDTH) with a 2-entry output buffer.
// Latency: a word accepted into an empty controller in cycle C is presented with out_valid in C+3.
// Backpressure: in_ready drops only when the SRAM is full; a stalled output stops SRAM reads once obuf+infl==2.
// Ports:
//   clk, rst                      clock (also clocks the SRAM macro), synchronous active-high reset
//   in_valid/in_ready/in_data     upstream valid-ready word interface
//   out_valid/out_ready/out_data  downstream valid-ready word interface (out_data = buffer head)
//   sram_csb0/addr0/din0          SRAM write port (csb active low)
//   sram_csb1/addr1/dout1         SRAM read port; dout1 is valid in the cycle after the read issue
//   count, full, empty            occupancy: all held words, SRAM full, nothing held
module sram_fifo_ctrl_240x32 #(
  parameter int DATA_WIDTH = 240,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [5:0]            count,
  output logic                  full,
  output logic                  empty
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      sram_cnt_q, sram_cnt_d;
  logic                  infl_q, infl_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;   // head entry
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
  logic [5:0]            count_q, count_d;

  logic       wr;
  logic       rd;
  logic       pop;
  logic [2:0] occ_after_pop;

  assign full      = (sram_cnt_q == DEPTH_CNT);
  assign in_ready  = !full && !rst;
  assign wr        = in_valid && in_ready;
  assign out_valid = (obuf_cnt_q != 2'd0) && !rst;
  assign pop       = out_valid && out_ready;

  // Output-side occupancy once this cycle's pop is taken; a read may issue only
  // if its word is guaranteed a buffer slot when it returns.
  assign occ_after_pop = {1'b0, obuf_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  // sram_cnt > 0 also keeps rptr != wptr whenever both ports are active.
  assign rd = !rst && (sram_cnt_q != '0) && (occ_after_pop < 3'd2);

  assign sram_csb0  = !wr;
  assign sram_addr0 = wptr_q;
  assign sram_din0  = in_data;
  assign sram_csb1  = !rd;
  assign sram_addr1 = rptr_q;

  assign out_data = obuf0_q;
  assign count    = count_q;
  assign empty    = (count_q == 6'd0);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;

    if (wr) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (rd) rptr_d = rptr_q + ADDR_WIDTH'(1);
    sram_cnt_d = sram_cnt_q + CNT_W'(wr) - CNT_W'(rd);

    // Data returns in the cycle after issue, so infl_q marks a capture this cycle.
    infl_d = rd;

    case ({infl_q, pop})
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = sram_dout1;
        else                    obuf1_d = sram_dout1;
        obuf_cnt_d = obuf_cnt_q + 2'd1;
      end
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the returning word goes behind whatever remains.
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = sram_dout1;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = sram_dout1;
        end
      end
      default: ;
    endcase

    count_d = 6'(sram_cnt_d) + 6'(infl_d) + 6'(obuf_cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      sram_cnt_q <= '0;
      infl_q     <= 1'b0;
      obuf_cnt_q <= 2'd0;
      count_q    <= 6'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sram_cnt_q <= sram_cnt_d;
      infl_q     <= infl_d;
      obuf_cnt_q <= obuf_cnt_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload needs no reset: it is only observed while obuf_cnt says it is valid.
  always_ff @(posedge clk) begin
    obuf0_q <= obuf0_d;
    obuf1_q <= obuf1_d;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl_240x32.sv
// Testbench for sram_fifo_ctrl_240x32 with a behavioural 1w1r SRAM and a FIFO scoreboard.
// Latency: n/a.
// Backpressure: drives random and directed out_ready stalls.
module tb_sram_fifo_ctrl_240x32;

  localparam int DW = 240;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;
  logic [5:0]    count;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  sram_fifo_ctrl_240x32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .count(count), .full(full), .empty(empty)
  );

  // SRAM macro: read data is held for exactly one cycle after the issue cycle,
  // then replaced by a junk pattern so a mistimed capture shows up as bad data.
  logic [DW-1:0] mem [32];
  logic [29:0]   junk_s = 30'h1EADBEEF;
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    else            sram_dout1 <= {8{junk_s}};
  end

  function automatic logic [DW-1:0] w(input int n);
    logic [29:0] s;
    s = n[29:0];
    return {8{s}};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic          stall_q = 1'b0;
  logic [DW-1:0] held_q;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stall_q = 1'b0;
    end else begin
      if (!sram_csb0 && !sram_csb1) check("addr_diff", 256'(sram_addr0 == sram_addr1), 256'd0);
      if (stall_q) check("stall_stable", out_data, held_q);
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (out_valid && out_ready) begin
        pops++;
        if (sb_q.size() == 0) check("sb_underflow", 256'd1, 256'd0);
        else                  check("sb_data", out_data, sb_q.pop_front());
      end
      stall_q = out_valid && !out_ready;
      held_q  = out_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int seq;
    logic seen;
    logic [29:0] a5_s;
    logic [DW-1:0] a5;
    a5_s = 30'h25A5A5A5;
    a5 = {30{8'hA5}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    nxt();
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_csb0", 256'(sram_csb0), 256'd1);
    check("rst_csb1", 256'(sram_csb1), 256'd1);
    check("rst_in_ready", 256'(in_ready), 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    nxt();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_count", 256'(count), 256'd0);
    check("post_rst_empty", 256'(empty), 256'd1);
    check("post_rst_full", 256'(full), 256'd0);
    check("post_rst_in_ready", 256'(in_ready), 256'd1);

    // Single word, cycle 0..4.
    nxt();
    in_valid = 1'b1; in_data = a5; out_ready = 1'b1;
    @(negedge clk);
    check("sw_csb0", 256'(sram_csb0), 256'd0);
    check("sw_addr0", 256'(sram_addr0), 256'd0);
    nxt();
    in_valid = 1'b0; in_data = {8{a5_s}};
    @(negedge clk);
    check("sw_csb1", 256'(sram_csb1), 256'd0);
    check("sw_addr1", 256'(sram_addr1), 256'd0);
    nxt();
    @(negedge clk);
    check("sw_c2_out_valid", 256'(out_valid), 256'd0);
    nxt();
    @(negedge clk);
    check("sw_c3_out_valid", 256'(out_valid), 256'd1);
    check("sw_c3_out_data", out_data, a5);
    check("sw_c3_count", 256'(count), 256'd1);
    nxt();
    @(negedge clk);
    check("sw_c4_empty", 256'(empty), 256'd1);
    check("sw_c4_out_valid", 256'(out_valid), 256'd0);

    // Fill with a stalled output: 32 in SRAM + 2 in the buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 34; i++) begin
      nxt();
      in_valid = 1'b1; in_data = w(i);
      @(negedge clk);
      check("fill_in_ready", 256'(in_ready), 256'd1);
    end
    nxt();
    in_data = w(99);
    @(negedge clk);
    check("fill_in_ready_low", 256'(in_ready), 256'd0);
    check("fill_csb0_idle", 256'(sram_csb0), 256'd1);
    check("fill_full", 256'(full), 256'd1);
    check("fill_count", 256'(count), 256'd34);

    // Drain: one word per cycle, in order.
    for (int i = 0; i < 34; i++) begin
      nxt();
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("drain_valid", 256'(out_valid), 256'd1);
      check("drain_data", out_data, w(i));
    end
    nxt();
    @(negedge clk);
    check("drain_out_valid", 256'(out_valid), 256'd0);
    check("drain_count", 256'(count), 256'd0);
    check("drain_empty", 256'(empty), 256'd1);

    // Streaming with wrap: write pointer starts at 35 mod 32 = 3.
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      nxt();
      in_valid = 1'b1; in_data = w(100 + i); out_ready = 1'b1;
      if (i == 0) begin
        @(negedge clk);
        check("stream_addr0_start", 256'(sram_addr0), 256'd3);
      end
    end
    nxt();
    in_valid = 1'b0;
    check("stream_pops", 256'(pops - p0), 256'd97);
    repeat (6) nxt();
    check("stream_sb_empty", 256'(sb_q.size()), 256'd0);
    check("stream_empty", 256'(empty), 256'd1);

    // Random backpressure, ~30% out_ready.
    seq = 1000;
    for (int k = 0; k < 300; k++) begin
      nxt();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = w(seq);
      out_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      if (in_valid && in_ready) seq++;
    end
    nxt();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) nxt();
    check("rand_sb_empty", 256'(sb_q.size()), 256'd0);
    check("rand_empty", 256'(empty), 256'd1);

    // Reset mid-stream with count 10 and a read in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      in_valid = 1'b1; in_data = w(500 + i);
    end
    nxt();
    in_data = w(510); out_ready = 1'b1;
    nxt();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_pre_count", 256'(count), 256'd10);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("mid_count", 256'(count), 256'd0);
    check("mid_out_valid", 256'(out_valid), 256'd0);
    check("mid_empty", 256'(empty), 256'd1);
    nxt();
    in_valid = 1'b1; in_data = w(7777); out_ready = 1'b1;
    nxt();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check("mid_next_word", out_data, w(7777));
      end
    end
    check("mid_word_seen", 256'(seen), 256'd1);
    nxt();
    @(negedge clk);
    check("mid_final_empty", 256'(empty), 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl_240x32.md
SRAM_FIFO_CTRL_240X32 -- requirements
Module: sram_fifo_ctrl_240x32

Interface
REQ-001 SHALL have parameters DATA_WIDTH, default 240, word width; ADDR_WIDTH, default 5, SRAM address width; DEPTH, default 32, SRAM entry count (1<<ADDR_WIDTH).
REQ-002 SHALL have one clock and a synchronous, active-high reset, listed first:
 clk  input  1  single clock; all state updates on posedge; drives clk0 and clk1 of the attached 1w1r SRAM macro
 rst  input  1  synchronous active-high reset
 in_valid  input  1  upstream word valid
 in_ready  output  1  controller can accept a word
 in_data  input  DATA_WIDTH  upstream word
 out_valid  output  1  head word valid
 out_ready  input  1  downstream accepts head word
 out_data  output  DATA_WIDTH  head word
 sram_csb0  output  1  write-port chip select, active low
 sram_addr0  output  ADDR_WIDTH  write address
 sram_din0  output  DATA_WIDTH  write data
 sram_csb1  output  1  read-port chip select, active low
 sram_addr1  output  ADDR_WIDTH  read address
 sram_dout1  input  DATA_WIDTH  read data; valid only at the first posedge after the read issue cycle
 count  output  6  total words held: SRAM + in flight + output buffer, 0..DEPTH+2
 full  output  1  SRAM holds DEPTH committed words
 empty  output  1  count == 0

Function
REQ-003 SHALL accept a word when in_valid && in_ready; in_ready = !full && !rst.
REQ-004 In an accept cycle SHALL drive sram_csb0=0, sram_addr0=wptr, sram_din0=in_data combinationally; wptr increments at the posedge. Otherwise sram_csb0=1.
REQ-005 SHALL keep sram_addr0=wptr and sram_din0=in_data in non-accept cycles; the macro ignores them while csb0=1.
REQ-006 SHALL track sram_cnt, the number of committed SRAM entries (0..DEPTH); full = (sram_cnt == DEPTH).
REQ-007 SHALL hold a 2-entry output buffer (obuf) and a 1-bit in-flight flag (infl).
REQ-008 SHALL define pop = out_valid && out_ready.
REQ-009 SHALL issue a read (sram_csb1=0, sram_addr1=rptr) iff !rst && sram_cnt>0 && (obuf_cnt + infl - pop) < 2; rptr increments and infl is set at that posedge. Otherwise sram_csb1=1.
REQ-010 SHALL capture sram_dout1 into obuf at the posedge ending the cycle after issue, then clear infl unless a new read issues in the same cycle.
REQ-011 SHALL never sample sram_dout1 at any other time; it is X after the hold window.
REQ-012 SHALL read only entries committed at an earlier posedge.
REQ-013 A write and a read in the same cycle SHALL always target different addresses.
REQ-014 sram_cnt next = sram_cnt + write - read_issue; simultaneous write and read at sram_cnt==0 is impossible, because the read requires sram_cnt>0.
REQ-015 wptr and rptr SHALL wrap DEPTH-1 -> 0 (natural ADDR_WIDTH modulo).
REQ-016 out_valid = (obuf_cnt>0); out_data = obuf head.
REQ-017 out_data SHALL stay stable while out_valid && !out_ready.
REQ-018 Simultaneous capture and pop SHALL keep obuf_cnt unchanged, with order preserved.
REQ-019 Latency: a word accepted into an empty controller in cycle C SHALL appear with out_valid=1 in cycle C+3.
REQ-020 Throughput SHALL be 1 word/cycle sustained on both sides when out_ready=1 and in_valid=1.
REQ-021 count = sram_cnt + infl + obuf_cnt, registered; empty = (count==0).
REQ-022 Data order SHALL be strictly FIFO; no word is dropped or duplicated across wrap-around.
REQ-023 A stalled downstream SHALL block further reads once obuf_cnt + infl == 2; writes continue until full.

Reset
REQ-024 While rst=1 at a posedge, SHALL clear wptr, rptr, sram_cnt, infl and obuf_cnt to 0.
REQ-025 While rst=1, SHALL drive sram_csb0=1, sram_csb1=1, in_ready=0, out_valid=0.
REQ-026 After rst, count=0, empty=1, full=0.
REQ-027 Reset mid-operation SHALL discard all stored and in-flight words; a read returning after reset is ignored (infl already cleared).

Verification
REQ-028 Single word: after reset, write 0xA5..A5 in cycle 0 with out_ready=1 -> csb0=0 addr0=0 in cycle 0; csb1=0 addr1=0 in cycle 1; out_valid=1, out_data=0xA5..A5 in cycle 3; empty=1 in cycle 4.
REQ-029 Fill: out_ready=0, write 34 incrementing words -> in_ready=0 after the 34th accept, full=1, count=34; no csb0=0 while full.
REQ-030 Drain after fill: out_ready=1 -> 34 words out in order 0..33, one per cycle after the first; count reaches 0, empty=1.
REQ-031 Streaming wrap: in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> output is an identical sequence; pointers wrap at 31; addr0 != addr1 whenever both csb are 0.
REQ-032 Backpressure: random out_ready at 30% duty and random in_valid -> scoreboard matches; out_data stable while stalled.
REQ-033 Reset mid-stream: assert rst for one cycle with count=10 and a read in flight -> next cycle count=0, out_valid=0; the next written word is the next output word.
